// File: rtl/mips_dbg_pkg.sv
// Shared debug-unit definitions: loader state encoding, byte/word geometry and the HALT default.
// Defining INST_LOADER_CKSUM_EN adds the CKSUM state to the encoding.
package mips_dbg_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

`ifdef INST_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_DONE,
    LD_ERROR,
    LD_CKSUM
  } ld_state_t;
`else
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_DONE,
    LD_ERROR
  } ld_state_t;
`endif

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word assembler: the word is presented combinationally together with
// the final byte so the loader can register it on the same edge that completes the word.
module byte_assembler
  import mips_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              clear,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  localparam int                CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int                HIST_W    = WORD_W - BYTE_W;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [HIST_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (rx_valid) begin
      shift_reg <= {shift_reg[HIST_W-BYTE_W-1:0], rx_data};
      cnt_reg   <= cnt_reg + CNT_W'(1);
    end
  end

  assign word       = {shift_reg, rx_data};
  assign word_ready = rx_valid && (cnt_reg == LAST_BYTE);

endmodule

// File: rtl/inst_loader.sv
// Debug instruction loader: assembles UART bytes into words and writes them into instruction
// memory while holding the CPU. INST_LOADER_CKSUM_EN adds a trailing XOR checksum byte.
module inst_loader
  import mips_dbg_pkg::*;
#(
  parameter int                MEM_DEPTH_WORDS = 256,
  parameter logic [WORD_W-1:0] HALT_WORD       = HALT_WORD_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [BYTE_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_write_en,
  output logic [WORD_W-1:0] o_data,
  output logic [WORD_W-1:0] o_addr_wr,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [WORD_W-1:0] o_word_count
`ifdef INST_LOADER_CKSUM_EN
  ,
  output logic              o_cksum_err
`endif
);

  // One extra index bit so that index == MEM_DEPTH_WORDS is representable for the bound check.
  localparam int               IDX_W     = $clog2(MEM_DEPTH_WORDS) + 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH_WORDS);

  ld_state_t         state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [WORD_W-1:0] count_reg, count_next;
  logic [WORD_W-1:0] data_reg, data_next;
  logic [WORD_W-1:0] addr_reg, addr_next;
  logic              write_en_reg, hold_reg, busy_reg, done_reg, error_reg;
  logic              hold_next;
  logic              accept, restart, halt_hit;
  logic [WORD_W-1:0] asm_word;
  logic              asm_ready;

`ifdef INST_LOADER_CKSUM_EN
  logic [BYTE_W-1:0] xor_reg, xor_next;
  logic              cksum_err_reg, cksum_err_next;
`endif

  byte_assembler u_assembler (
    .clk        (i_clk),
    .srst       (i_reset),
    .clear      (restart),
    .rx_valid   (accept),
    .rx_data    (i_rx_data),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

  // data_reg holds the word being written while in WRITE
  assign halt_hit = (data_reg == HALT_WORD);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    data_next  = data_reg;
    addr_next  = addr_reg;
    accept     = 1'b0;
    restart    = 1'b0;
`ifdef INST_LOADER_CKSUM_EN
    xor_next       = xor_reg;
    cksum_err_next = cksum_err_reg;
`endif

    case (state_reg)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (i_start) begin
          restart    = 1'b1;
          state_next = LD_RECV;
          idx_next   = '0;
          count_next = '0;
        end
      end
      LD_RECV: begin
        accept = i_rx_valid;
        if (asm_ready) begin
          if (idx_reg < DEPTH_IDX) begin
            state_next = LD_WRITE;
            data_next  = asm_word;
            addr_next  = WORD_W'(idx_reg) << 2;
          end else begin
            state_next = LD_ERROR;
          end
        end
      end
      LD_WRITE: begin
        idx_next   = idx_reg + IDX_W'(1);
        count_next = count_reg + WORD_W'(1);
        if (halt_hit) begin
`ifdef INST_LOADER_CKSUM_EN
          state_next = LD_CKSUM;
`else
          state_next = LD_DONE;
`endif
        end else begin
          // a byte landing here starts the next word
          state_next = LD_RECV;
          accept     = i_rx_valid;
        end
      end
`ifdef INST_LOADER_CKSUM_EN
      LD_CKSUM: begin
        if (i_rx_valid) begin
          if (i_rx_data == xor_reg) begin
            state_next = LD_DONE;
          end else begin
            state_next     = LD_ERROR;
            cksum_err_next = 1'b1;
          end
        end
      end
`endif
      default: state_next = LD_IDLE;
    endcase

`ifdef INST_LOADER_CKSUM_EN
    if (restart) begin
      xor_next       = '0;
      cksum_err_next = 1'b0;
    end else if (accept) begin
      xor_next = xor_reg ^ i_rx_data;
    end
    hold_next = (state_next == LD_RECV) || (state_next == LD_WRITE) || (state_next == LD_CKSUM);
`else
    hold_next = (state_next == LD_RECV) || (state_next == LD_WRITE);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= LD_IDLE;
      idx_reg      <= '0;
      count_reg    <= '0;
      data_reg     <= '0;
      addr_reg     <= '0;
      write_en_reg <= 1'b0;
      hold_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      count_reg    <= count_next;
      data_reg     <= data_next;
      addr_reg     <= addr_next;
      write_en_reg <= (state_next == LD_WRITE);
      hold_reg     <= hold_next;
      busy_reg     <= (state_next == LD_RECV) || (state_next == LD_WRITE);
      done_reg     <= (state_next == LD_DONE);
      error_reg    <= (state_next == LD_ERROR);
    end
  end

`ifdef INST_LOADER_CKSUM_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      xor_reg       <= '0;
      cksum_err_reg <= 1'b0;
    end else begin
      xor_reg       <= xor_next;
      cksum_err_reg <= cksum_err_next;
    end
  end

  assign o_cksum_err = cksum_err_reg;
`endif

  assign o_write_en   = write_en_reg;
  assign o_data       = data_reg;
  assign o_addr_wr    = addr_reg;
  assign o_cpu_hold   = hold_reg;
  assign o_busy       = busy_reg;
  assign o_done       = done_reg;
  assign o_error      = error_reg;
  assign o_word_count = count_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: table vectors, hand-written corner sequences and random loads
// checked against a word-level model. Build with INST_LOADER_CKSUM_EN to cover the checksum.
module tb_inst_loader;
  import mips_dbg_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        write_en, cpu_hold, busy, done, error;
  logic [31:0] data, addr_wr, word_count;
`ifdef INST_LOADER_CKSUM_EN
  logic        cksum_err;
`endif

  inst_loader #(.MEM_DEPTH_WORDS(DEPTH), .HALT_WORD(HALT)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_write_en   (write_en),
    .o_data       (data),
    .o_addr_wr    (addr_wr),
    .o_cpu_hold   (cpu_hold),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_word_count (word_count)
`ifdef INST_LOADER_CKSUM_EN
    ,
    .o_cksum_err  (cksum_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] got_q[$];     // {addr, data} of every observed write
  logic [63:0] exp_q[$];
  logic [31:0] load_words[$];
  bit          m_done, m_err;

  always @(negedge clk) if (write_en) got_q.push_back({addr_wr, data});

  typedef struct packed {
    logic [5:0][31:0] words;
    int               n;
    int               gap;
    int               exp_writes;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  // Word-level model: word i goes to byte address 4*i while i < DEPTH; HALT ends with DONE,
  // a word beyond the bound ends with ERROR and is not written.
  task automatic model_load();
    exp_q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    foreach (load_words[i]) begin
      if (i >= DEPTH) begin
        m_err = 1'b1;
        break;
      end
      exp_q.push_back({32'(i * 4), load_words[i]});
      if (load_words[i] == HALT) begin
        m_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_load(input int gmin, input int gmax, input bit send_ck, input bit good_ck);
    logic [7:0] x;
    x = 8'h00;
    got_q.delete();
    pulse_start();
    foreach (load_words[i]) begin
      for (int b = 3; b >= 0; b--) begin
        x ^= load_words[i][b*8 +: 8];
        send_byte(load_words[i][b*8 +: 8], int'($urandom_range(gmax, gmin)));
      end
    end
    if (send_ck) begin
      tick(1);
`ifdef INST_LOADER_CKSUM_EN
      send_byte(good_ck ? x : ~x, 0);
`else
      if (good_ck) tick(1);
`endif
    end
    tick(3);
  endtask

  task automatic compare_load(input string tag, input bit e_done, input bit e_err, input bit e_ck);
    logic [63:0] g;
    chk({tag, " writes"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 64'h0;
      chk({tag, " addr"}, g[63:32], exp_q[i][63:32]);
      chk({tag, " data"}, g[31:0], exp_q[i][31:0]);
    end
    chk({tag, " done"}, 32'(done), 32'(e_done));
    chk({tag, " error"}, 32'(error), 32'(e_err));
    chk({tag, " count"}, word_count, 32'(exp_q.size()));
    chk({tag, " hold"}, 32'(cpu_hold), 32'(!e_done && !e_err));
    chk({tag, " busy"}, 32'(busy), 32'(!e_done && !e_err));
`ifdef INST_LOADER_CKSUM_EN
    chk({tag, " cksum_err"}, 32'(cksum_err), 32'(e_ck));
`else
    if (e_ck) chk({tag, " cksum_flag"}, 32'(error), 32'(1));
`endif
    $display("%s: %0d words sent, %0d writes seen, done=%0b error=%0b count=%0d",
             tag, load_words.size(), got_q.size(), done, error, word_count);
    if (!e_done && !e_err) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    logic [63:0] g;
    int          n_max;
    bit          good, e_done, e_err, e_ck;

    vecs[0] = '0; vecs[0].words[0] = 32'h2008_0005; vecs[0].words[1] = HALT;
    vecs[0].n = 2; vecs[0].gap = 1; vecs[0].exp_writes = 2; vecs[0].exp_done = 1;
    vecs[1] = '0; vecs[1].words[0] = 32'h0102_0304; vecs[1].words[1] = 32'h0506_0708;
    vecs[1].n = 2; vecs[1].gap = 0; vecs[1].exp_writes = 2;
    vecs[2] = '0; vecs[2].words[0] = 32'h1111_1111; vecs[2].words[1] = 32'h2222_2222;
    vecs[2].words[2] = 32'h3333_3333; vecs[2].words[3] = 32'h4444_4444; vecs[2].words[4] = 32'h5555_5555;
    vecs[2].n = 5; vecs[2].gap = 0; vecs[2].exp_writes = 4; vecs[2].exp_err = 1;
    vecs[3] = '0; vecs[3].words[0] = HALT;
    vecs[3].n = 1; vecs[3].gap = 2; vecs[3].exp_writes = 1; vecs[3].exp_done = 1;
    vecs[4] = '0; vecs[4].words[0] = 32'hA000_0001; vecs[4].words[1] = 32'hA000_0002;
    vecs[4].words[2] = 32'hA000_0003; vecs[4].words[3] = HALT;
    vecs[4].n = 4; vecs[4].gap = 0; vecs[4].exp_writes = 4; vecs[4].exp_done = 1;
    vecs[5] = '0; vecs[5].words[0] = 32'hB000_0001; vecs[5].words[1] = 32'hB000_0002;
    vecs[5].words[2] = 32'hB000_0003; vecs[5].words[3] = 32'hB000_0004; vecs[5].words[4] = HALT;
    vecs[5].n = 5; vecs[5].gap = 1; vecs[5].exp_writes = 4; vecs[5].exp_err = 1;

    do_reset();
    chk("reset write_en", 32'(write_en), 32'(0));
    chk("reset data", data, 32'h0);
    chk("reset addr", addr_wr, 32'h0);
    chk("reset hold", 32'(cpu_hold), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset error", 32'(error), 32'(0));
    chk("reset count", word_count, 32'h0);
`ifdef INST_LOADER_CKSUM_EN
    chk("reset cksum_err", 32'(cksum_err), 32'(0));
`endif

    // Write latency and restart from DONE
    got_q.delete();
    pulse_start();
    send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0);
    rx_valid = 1'b1; rx_data = 8'h05;
    @(negedge clk);
    chk("lat pre write_en", 32'(write_en), 32'(0));
    chk("lat pre hold", 32'(cpu_hold), 32'(1));
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("lat write_en", 32'(write_en), 32'(1));
    chk("lat data", data, 32'h2008_0005);
    chk("lat addr", addr_wr, 32'h0);
    @(negedge clk);
    chk("lat pulse width", 32'(write_en), 32'(0));
    chk("lat count", word_count, 32'd1);
    @(posedge clk); #1;
    send_word(HALT, 0);
`ifdef INST_LOADER_CKSUM_EN
    tick(1);
    send_byte(8'h2D, 0);
`endif
    tick(3);
    chk("halt done", 32'(done), 32'(1));
    chk("halt hold", 32'(cpu_hold), 32'(0));
    chk("halt count", word_count, 32'd2);
    g = (got_q.size() > 1) ? got_q[1] : 64'h0;
    chk("halt write", g[31:0], HALT);
    chk("halt addr", g[63:32], 32'h4);
    $display("latency load: %0d writes, done=%0b", got_q.size(), done);
    got_q.delete();
    pulse_start();
    @(negedge clk);
    chk("restart done", 32'(done), 32'(0));
    chk("restart count", word_count, 32'h0);
    chk("restart busy", 32'(busy), 32'(1));
    @(posedge clk); #1;
    send_word(HALT, 0);
`ifdef INST_LOADER_CKSUM_EN
    tick(1);
    send_byte(8'h00, 0);
`endif
    tick(3);
    g = (got_q.size() > 0) ? got_q[0] : 64'h1;
    chk("restart addr", g[63:32], 32'h0);
    chk("restart count2", word_count, 32'd1);
    $display("restart load: %0d writes, done=%0b", got_q.size(), done);

    // i_start while busy is ignored
    got_q.delete();
    pulse_start();
    send_word(32'h0000_0011, 1);
    pulse_start();
    send_word(32'h0000_0022, 0);
    send_word(HALT, 0);
`ifdef INST_LOADER_CKSUM_EN
    tick(1);
    send_byte(8'h33, 0);
`endif
    tick(3);
    g = (got_q.size() > 1) ? got_q[1] : 64'h0;
    chk("busy start addr", g[63:32], 32'h4);
    chk("busy start count", word_count, 32'd3);
    $display("busy-start load: %0d writes, done=%0b", got_q.size(), done);

    // Reset mid-word drops partial bytes
    got_q.delete();
    pulse_start();
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("midreset no write", 32'(got_q.size()), 32'd0);
    chk("midreset busy", 32'(busy), 32'(0));
    pulse_start();
    send_word(32'hAABB_CCDD, 0);
    tick(2);
    g = (got_q.size() > 0) ? got_q[0] : 64'h0;
    chk("midreset data", g[31:0], 32'hAABB_CCDD);
    chk("midreset addr", g[63:32], 32'h0);
    $display("mid-reset load: %0d writes, data=%h", got_q.size(), g[31:0]);
    do_reset();

`ifdef INST_LOADER_CKSUM_EN
    // Byte during the HALT write is dropped, then good checksum
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_word(HALT, 0);
    send_byte(8'h77, 0);
    @(negedge clk);
    chk("cksum hold", 32'(cpu_hold), 32'(1));
    @(posedge clk); #1;
    send_byte(8'h01, 0);
    tick(2);
    chk("cksum good done", 32'(done), 32'(1));
    chk("cksum good err", 32'(cksum_err), 32'(0));
    $display("checksum load good: done=%0b error=%0b", done, error);
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_word(HALT, 0);
    tick(1);
    send_byte(8'h00, 0);
    tick(2);
    chk("cksum bad error", 32'(error), 32'(1));
    chk("cksum bad flag", 32'(cksum_err), 32'(1));
    chk("cksum bad done", 32'(done), 32'(0));
    $display("checksum load bad: done=%0b error=%0b", done, error);
    pulse_start();
    @(negedge clk);
    chk("cksum flag clears", 32'(cksum_err), 32'(0));
    do_reset();
`endif

    for (int v = 0; v < 6; v++) begin
      load_words.delete();
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++) load_words.push_back(vecs[v].words[i]);
      for (int i = 0; i < vecs[v].exp_writes; i++) exp_q.push_back({32'(i * 4), vecs[v].words[i]});
      run_load(vecs[v].gap, vecs[v].gap, vecs[v].exp_done, 1'b1);
      compare_load($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, 1'b0);
    end

    for (int t = 0; t < 40; t++) begin
      load_words.delete();
      n_max = int'($urandom_range(6, 1));
      for (int k = 0; k < n_max; k++) begin
        w = ($urandom_range(3, 0) == 0) ? HALT : $urandom;
        load_words.push_back(w);
        if (w == HALT) break;
      end
      good = 1'($urandom_range(1, 0));
      model_load();
      e_done = m_done;
      e_err  = m_err;
      e_ck   = 1'b0;
`ifdef INST_LOADER_CKSUM_EN
      if (m_done && !good) begin
        e_done = 1'b0;
        e_err  = 1'b1;
        e_ck   = 1'b1;
      end
`endif
      run_load(0, 2, m_done, good);
      compare_load($sformatf("rand%0d", t), e_done, e_err, e_ck);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
